lzrw1_item_parser: RTL and testbench
====================================

Name: lzrw1_item_parser

Overview:
- Upstream feeder for decompressor_top; converts a raw LZRW1 compressed byte stream into (item, flag) pairs.
- Consumes one byte per handshake, extracts 16-bit control words and splits the payload into literal items (1 byte) and copy items (2 bytes).
- Presents each item on data_out with its flag bit on control_word_out, paced by the decompressor's busy signal.

Parameters:
- CW_BITS, 16, items per control word; fixed format value; only 16 is supported.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- byte_in  input  8  compressed stream byte
- byte_in_valid  input  1  byte_in holds a valid byte
- byte_last  input  1  qualifies byte_in as the final stream byte
- byte_in_ready  output  1  parser accepts byte_in this cycle
- data_out  output  16  item to decompressor (drives data_in)
- control_word_out  output  1  flag for data_out: 0 = literal, 1 = copy
- data_out_valid  output  1  item valid (drives data_in_valid)
- decompressor_busy  input  1  decompressor is busy; no transfer while high
- done  output  1  stream fully parsed and issued; sticky
- error  output  1  stream truncated mid-structure; sticky

Behaviour:
- Clock and reset: clock is the single clock. reset is synchronous and active-high.
- Reset values: byte_in_ready=0, data_out=16'h0000, control_word_out=0, data_out_valid=0, done=0, error=0. Internal state is CW_LO, bit index 0, control word 0.
- Reset mid-operation: any held item is discarded and parsing restarts at CW_LO. Reset takes priority over every other event.
- Byte accept: a byte is taken on a cycle where byte_in_valid && byte_in_ready.
- byte_in_ready is 1 only in the CW_LO, CW_HI, ITEM_B0 and ITEM_B1 states.
- Item transfer: occurs on a cycle where data_out_valid && !decompressor_busy.
  - data_out_valid deasserts on the next cycle.
  - data_out and control_word_out stay stable while valid is high.
  - The next item is presented no earlier than the cycle after a transfer.
- FSM states:
  - CW_LO: accept byte into cw[7:0]. Go to CW_HI.
  - CW_HI: accept byte into cw[15:8]. Set bit index to 0 and go to ITEM_B0.
  - ITEM_B0:
    - Accept byte b0.
    - If cw[idx]==0: data_out={8'h00,b0}, control_word_out=0, go to EMIT.
    - Otherwise store b0 and go to ITEM_B1.
  - ITEM_B1: accept byte b1. Set data_out={b0,b1}, control_word_out=1, go to EMIT.
  - EMIT:
    - Hold data_out_valid=1 until the item transfers.
    - On transfer: idx increments.
    - If the item's byte was last: go to DONE.
    - Else if idx was 15: go to CW_LO (idx wraps to 0).
    - Else: go to ITEM_B0.
  - DONE: done=1, byte_in_ready=0. Stay until reset.
  - ERR: error=1, byte_in_ready=0. Stay until reset.
- Copy item bytes are packed first-byte-in-high: data_out[15:12]=offset high nibble, [11:8]=length-1, [7:0]=offset low byte. The parser does not interpret these fields.
- byte_last boundary rules:
  - On a CW_LO byte: go to ERR.
  - On a CW_HI byte: go to DONE. A control word with no items is legal.
  - On an ITEM_B0 byte whose flag is 1: go to ERR (copy item truncated).
  - On a literal byte or an ITEM_B1 byte: the item is issued, then go to DONE.
- Unused control word bits after the final item are ignored.
- Latency: a literal is presented 1 cycle after its byte is accepted. A copy item is presented 1 cycle after its second byte.
- Back-pressure: no bytes are accepted while in EMIT. Any stall is absorbed by byte_in_valid low.

Optional Feature:
- Macro: LZRW1_HEADER_EN.
- When defined:
  - A HDR state precedes CW_LO and accepts 4 header bytes, little-endian, into a 32-bit flag.
  - Flag==1 (raw copy): every later byte is issued as a literal with control_word_out=0. No control words are parsed. byte_last leads to DONE after its item.
  - Flag==0: normal parsing.
  - Any other flag value goes to ERR.
  - byte_last during the header goes to ERR.
- When undefined: there is no HDR state. Parsing starts at CW_LO, and the logic is absent.

Test Plan:
- All-literal stream: bytes 00 00 41 42 43(last) -> items {0041,0},{0042,0},{0043,0} -> done=1, error=0.
- Mixed stream: cw bytes 02 00, then 41, 10 05, 42(last) -> {0041,0},{1005,1},{0042,0} -> done=1.
- Control word wrap: cw FFFF followed by 16 copy items, then cw 0000 and literal 58(last) -> 16 copies, then {0058,0}. The 17th item is read from the second control word.
- Busy stall: hold decompressor_busy=1 for 10 cycles while data_out_valid=1 -> data_out is stable, byte_in_ready=0, and exactly one transfer occurs when busy drops.
- Truncation: cw 01 00, then byte 10 with byte_last=1 -> error=1, no item issued, done=0. Also last on a CW_LO byte -> error=1.
- Reset mid-copy: assert reset after the ITEM_B0 byte of a copy item -> all outputs return to reset values, and a new stream 00 00 41(last) gives {0041,0}.

Source files
------------

// File: rtl/lzrw1_item_parser.sv
// lzrw1_item_parser: turns a raw LZRW1 compressed byte stream into
// (item, flag) pairs for the decompressor. The parser reads a 16-bit control
// word, then one literal byte or a two-byte copy per control word bit. Each
// item is held on data_out until the decompressor takes it.
// Optional build macro LZRW1_HEADER_EN adds a 4-byte little-endian header
// ahead of the stream. A header value of 1 selects raw mode, where every byte
// is passed through as a literal.
module lzrw1_item_parser #(
  parameter int unsigned CW_BITS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_in_valid,
  input  logic        byte_last,
  output logic        byte_in_ready,
  output logic [15:0] data_out,
  output logic        control_word_out,
  output logic        data_out_valid,
  input  logic        decompressor_busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned IDX_W = $clog2(CW_BITS);

  typedef enum logic [2:0] {
    ST_CW_LO,
    ST_CW_HI,
    ST_ITEM_B0,
    ST_ITEM_B1,
    ST_EMIT,
    ST_DONE,
    ST_ERR
`ifdef LZRW1_HEADER_EN
    , ST_HDR
`endif
  } state_t;

  state_t             state;
  logic [15:0]        cw;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         b0;
  logic               item_last;
  logic               accept;
  logic               is_copy;

`ifdef LZRW1_HEADER_EN
  logic [1:0]         hdr_cnt;
  logic [23:0]        hdr;
  logic               raw_mode;

  // In raw mode every payload byte is a literal, whatever cw holds
  assign is_copy = !raw_mode && cw[idx];
`else
  assign is_copy = cw[idx];
`endif

  assign accept = byte_in_valid && byte_in_ready;

  // Parser FSM; all outputs are registered alongside the state
  always_ff @(posedge clock) begin
    if (reset) begin
`ifdef LZRW1_HEADER_EN
      state    <= ST_HDR;
      hdr_cnt  <= 2'd0;
      hdr      <= 24'h0;
      raw_mode <= 1'b0;
`else
      state    <= ST_CW_LO;
`endif
      cw               <= 16'h0000;
      idx              <= '0;
      b0               <= 8'h00;
      item_last        <= 1'b0;
      byte_in_ready    <= 1'b0;
      data_out         <= 16'h0000;
      control_word_out <= 1'b0;
      data_out_valid   <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      case (state)
`ifdef LZRW1_HEADER_EN
        ST_HDR: begin
          if (accept) begin
            hdr_cnt <= hdr_cnt + 2'd1;
            if (byte_last) begin
              state         <= ST_ERR;
              error         <= 1'b1;
              byte_in_ready <= 1'b0;
            end else if (hdr_cnt == 2'd3) begin
              if ({byte_in, hdr} == 32'd1) begin
                raw_mode <= 1'b1;
                state    <= ST_ITEM_B0;
              end else if ({byte_in, hdr} == 32'd0) begin
                state <= ST_CW_LO;
              end else begin
                state         <= ST_ERR;
                error         <= 1'b1;
                byte_in_ready <= 1'b0;
              end
            end else begin
              hdr[8*hdr_cnt +: 8] <= byte_in;
            end
          end else begin
            byte_in_ready <= 1'b1;
          end
        end
`endif
        ST_CW_LO: begin
          if (accept) begin
            cw[7:0] <= byte_in;
            if (byte_last) begin
              state         <= ST_ERR;
              error         <= 1'b1;
              byte_in_ready <= 1'b0;
            end else begin
              state <= ST_CW_HI;
            end
          end else begin
            byte_in_ready <= 1'b1;
          end
        end

        ST_CW_HI: begin
          if (accept) begin
            cw[15:8] <= byte_in;
            idx      <= '0;
            if (byte_last) begin
              state         <= ST_DONE;
              done          <= 1'b1;
              byte_in_ready <= 1'b0;
            end else begin
              state <= ST_ITEM_B0;
            end
          end else begin
            byte_in_ready <= 1'b1;
          end
        end

        ST_ITEM_B0: begin
          if (accept) begin
            if (!is_copy) begin
              data_out         <= {8'h00, byte_in};
              control_word_out <= 1'b0;
              data_out_valid   <= 1'b1;
              item_last        <= byte_last;
              state            <= ST_EMIT;
              byte_in_ready    <= 1'b0;
            end else if (byte_last) begin
              state         <= ST_ERR;
              error         <= 1'b1;
              byte_in_ready <= 1'b0;
            end else begin
              b0    <= byte_in;
              state <= ST_ITEM_B1;
            end
          end else begin
            byte_in_ready <= 1'b1;
          end
        end

        ST_ITEM_B1: begin
          if (accept) begin
            data_out         <= {b0, byte_in};
            control_word_out <= 1'b1;
            data_out_valid   <= 1'b1;
            item_last        <= byte_last;
            state            <= ST_EMIT;
            byte_in_ready    <= 1'b0;
          end else begin
            byte_in_ready <= 1'b1;
          end
        end

        ST_EMIT: begin
          if (!decompressor_busy) begin
            data_out_valid <= 1'b0;
            idx            <= idx + IDX_W'(1);
            if (item_last) begin
              state <= ST_DONE;
              done  <= 1'b1;
`ifdef LZRW1_HEADER_EN
            end else if (raw_mode) begin
              state         <= ST_ITEM_B0;
              byte_in_ready <= 1'b1;
`endif
            end else if (idx == IDX_W'(CW_BITS - 1)) begin
              state         <= ST_CW_LO;
              byte_in_ready <= 1'b1;
            end else begin
              state         <= ST_ITEM_B0;
              byte_in_ready <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          byte_in_ready <= 1'b0;
          done          <= 1'b1;
        end

        ST_ERR: begin
          byte_in_ready <= 1'b0;
          error         <= 1'b1;
        end

        default: begin
          state         <= ST_ERR;
          byte_in_ready <= 1'b0;
          error         <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzrw1_item_parser.sv
// Scoreboard bench for lzrw1_item_parser (default build, no header).
// Expected items are pushed when a stream is issued; a monitor pops and
// compares on every item transfer.
module tb_lzrw1_item_parser;

  logic        clock;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_in_valid;
  logic        byte_last;
  logic        byte_in_ready;
  logic [15:0] data_out;
  logic        control_word_out;
  logic        data_out_valid;
  logic        decompressor_busy;
  logic        done;
  logic        error;

  lzrw1_item_parser dut (
    .clock             (clock),
    .reset             (reset),
    .byte_in           (byte_in),
    .byte_in_valid     (byte_in_valid),
    .byte_last         (byte_last),
    .byte_in_ready     (byte_in_ready),
    .data_out          (data_out),
    .control_word_out  (control_word_out),
    .data_out_valid    (data_out_valid),
    .decompressor_busy (decompressor_busy),
    .done              (done),
    .error             (error)
  );

  logic [7:0]  sb[$];
  bit          sl[$];
  logic [16:0] expq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_xfer = 0;
  int          busy_mode = 1;  // 0 random, 1 never busy, 2 always busy

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Busy generator, updated just after each rising edge
  initial begin
    decompressor_busy = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (busy_mode == 0) decompressor_busy = ($urandom_range(0, 3) == 0);
      else decompressor_busy = (busy_mode == 2);
    end
  end

  // Monitor: every transfer must match the head of the scoreboard
  always @(negedge clock) begin
    if (!reset && data_out_valid && !decompressor_busy) begin
      n_xfer++;
      if (expq.size() == 0) begin
        check("unexpected_item", {15'h0, control_word_out, data_out}, 32'h1ffff);
      end else begin
        check("item", {15'h0, control_word_out, data_out}, {15'h0, expq.pop_front()});
      end
    end
  end

  // Reference: walk the byte list by the format rules, collecting items
  task automatic model(output bit md, output bit me);
    int p;
    logic [15:0] cw;
    p = 0; md = 0; me = 0;
    while (p < sb.size()) begin
      cw[7:0] = sb[p];
      if (sl[p]) begin me = 1; return; end
      p++;
      if (p >= sb.size()) return;
      cw[15:8] = sb[p];
      if (sl[p]) begin md = 1; return; end
      p++;
      for (int i = 0; i < 16; i++) begin
        if (p >= sb.size()) return;
        if (cw[i]) begin
          if (sl[p]) begin me = 1; return; end
          if (p + 1 >= sb.size()) return;
          expq.push_back({1'b1, sb[p], sb[p+1]});
          if (sl[p+1]) begin md = 1; return; end
          p += 2;
        end else begin
          expq.push_back({1'b0, 8'h00, sb[p]});
          if (sl[p]) begin md = 1; return; end
          p++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    expq.delete();
    check("rst_ready", {31'h0, byte_in_ready}, 32'h0);
    check("rst_data", {16'h0, data_out}, 32'h0);
    check("rst_flag", {31'h0, control_word_out}, 32'h0);
    check("rst_valid", {31'h0, data_out_valid}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_error", {31'h0, error}, 32'h0);
    reset = 1'b0;
  endtask

  // Drive sb/sl one byte per handshake with random idle gaps
  task automatic send_stream();
    int cnt;
    for (int i = 0; i < sb.size(); i++) begin
      repeat ($urandom_range(0, 2)) step();
      byte_in = sb[i];
      byte_last = sl[i];
      byte_in_valid = 1'b1;
      cnt = 0;
      do begin
        @(negedge clock);
        cnt++;
      end while (!byte_in_ready && cnt < 300);
      if (cnt >= 300) begin
        check("accept_timeout", 32'd1, 32'd0);
        byte_in_valid = 1'b0;
        byte_last = 1'b0;
        return;
      end
      step();
      byte_in_valid = 1'b0;
      byte_last = 1'b0;
    end
  endtask

  task automatic finish_check(input string tag, input bit ed, input bit ee);
    int cnt;
    cnt = 0;
    while (!(done || error) && cnt < 500) begin @(negedge clock); cnt++; end
    cnt = 0;
    while (expq.size() != 0 && cnt < 500) begin @(negedge clock); cnt++; end
    repeat (3) @(negedge clock);
    check({tag, "_done"}, {31'h0, done}, {31'h0, ed});
    check({tag, "_error"}, {31'h0, error}, {31'h0, ee});
    check({tag, "_left"}, expq.size(), 32'd0);
  endtask

  task automatic set_stream(input logic [7:0] b[], input int last_at);
    sb.delete();
    sl.delete();
    foreach (b[i]) begin
      sb.push_back(b[i]);
      sl.push_back(i == last_at);
    end
  endtask

  initial begin
    logic [7:0] v[];
    logic [15:0] hold;
    bit md, me;
    int x0, cnt, n;
    reset = 1'b1;
    byte_in = 8'h00;
    byte_in_valid = 1'b0;
    byte_last = 1'b0;

    // All-literal stream
    do_reset();
    v = '{8'h00, 8'h00, 8'h41, 8'h42, 8'h43};
    set_stream(v, 4);
    expq.push_back({1'b0, 16'h0041});
    expq.push_back({1'b0, 16'h0042});
    expq.push_back({1'b0, 16'h0043});
    send_stream();
    finish_check("literals", 1, 0);

    // Mixed literal/copy stream with random back-pressure
    busy_mode = 0;
    do_reset();
    v = '{8'h02, 8'h00, 8'h41, 8'h10, 8'h05, 8'h42};
    set_stream(v, 5);
    expq.push_back({1'b0, 16'h0041});
    expq.push_back({1'b1, 16'h1005});
    expq.push_back({1'b0, 16'h0042});
    send_stream();
    finish_check("mixed", 1, 0);

    // Control word wrap: 16 copies then a second control word
    do_reset();
    v = new[37];
    v[0] = 8'hff; v[1] = 8'hff;
    for (int i = 0; i < 16; i++) begin
      v[2 + 2*i] = 8'(8'h20 + i);
      v[3 + 2*i] = 8'(8'h80 + i);
      expq.push_back({1'b1, 8'(8'h20 + i), 8'(8'h80 + i)});
    end
    v[34] = 8'h00; v[35] = 8'h00; v[36] = 8'h58;
    expq.push_back({1'b0, 16'h0058});
    set_stream(v, 36);
    send_stream();
    finish_check("wrap", 1, 0);

    // Busy stall: item held stable for 10 cycles, then exactly one transfer
    busy_mode = 2;
    do_reset();
    v = '{8'h00, 8'h00, 8'h41};
    set_stream(v, 2);
    expq.push_back({1'b0, 16'h0041});
    send_stream();
    cnt = 0;
    while (!data_out_valid && cnt < 50) begin @(negedge clock); cnt++; end
    check("stall_valid_seen", {31'h0, data_out_valid}, 32'h1);
    hold = data_out;
    x0 = n_xfer;
    repeat (10) begin
      @(negedge clock);
      check("stall_data", {16'h0, data_out}, 32'h0041);
      check("stall_ready", {31'h0, byte_in_ready}, 32'h0);
      check("stall_valid", {31'h0, data_out_valid}, 32'h1);
    end
    check("stall_hold", {16'h0, data_out}, {16'h0, hold});
    busy_mode = 1;
    repeat (4) @(negedge clock);
    check("stall_xfers", n_xfer - x0, 32'd1);
    check("stall_valid_off", {31'h0, data_out_valid}, 32'h0);
    finish_check("stall", 1, 0);

    // Truncated copy: last on a copy first byte
    busy_mode = 0;
    do_reset();
    v = '{8'h01, 8'h00, 8'h10};
    set_stream(v, 2);
    send_stream();
    finish_check("trunc_copy", 0, 1);

    // Last on the control word low byte
    do_reset();
    v = '{8'h00};
    set_stream(v, 0);
    send_stream();
    finish_check("trunc_cw", 0, 1);

    // Empty control word terminated on its high byte
    do_reset();
    v = '{8'h00, 8'h00};
    set_stream(v, 1);
    send_stream();
    finish_check("empty_cw", 1, 0);

    // Reset after the first byte of a copy item
    do_reset();
    v = '{8'h01, 8'h00, 8'h10};
    set_stream(v, -1);
    send_stream();
    step();
    step();
    do_reset();
    v = '{8'h00, 8'h00, 8'h41};
    set_stream(v, 2);
    expq.push_back({1'b0, 16'h0041});
    send_stream();
    finish_check("after_reset", 1, 0);

    // Random streams checked against the reference model
    for (int t = 0; t < 40; t++) begin
      do_reset();
      n = $urandom_range(1, 45);
      sb.delete();
      sl.delete();
      for (int i = 0; i < n; i++) begin
        sb.push_back(8'($urandom));
        sl.push_back(i == n - 1);
      end
      model(md, me);
      send_stream();
      finish_check("random", md, me);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
